muldiv_seq: RTL and testbench

- Iterative 8-bit multiply/divide unit with its own sequencing FSM and a start/busy/done handshake.
- Serves the CPU controller's MUL and DIV execute states. The controller pulses start with the ACC/MDR operands, holds in its wait state until done, then loads the result into ACC.
- Replaces any single-cycle arithmetic for MUL/DIV. One shift-add or shift-subtract step per clock.

---
 rtl/muldiv_seq_pkg.sv | 7 +
 rtl/muldiv_seq_if.sv | 14 +
 rtl/muldiv_datapath.sv | 51 +++++
 rtl/muldiv_seq.sv | 68 ++++++
 tb/tb_muldiv_seq.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared op encoding, FSM states and default width for the mul/div unit
package muldiv_seq_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: start/busy/done handshake and operand/result bus of the mul/div unit
interface muldiv_seq_if #(parameter int WIDTH = muldiv_seq_pkg::DEF_WIDTH);
  logic start;
  logic op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic div_zero;
  modport master (output start, op, a, b, input busy, done, result, result_hi, div_zero);
  modport slave (input start, op, a, b, output busy, done, result, result_hi, div_zero);
endinterface

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: shift-add multiply / restoring divide registers with one step per strobe
module muldiv_datapath
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next
);
  logic             op_r;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;
  // next accumulator value: lo holds multiplier/quotient, hi holds product high/remainder
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    rem_sh  = {hi, lo[WIDTH-1]};
    ge      = rem_sh >= {1'b0, opnd};
    diff    = rem_sh[WIDTH-1:0] - opnd;
    lo_next = (op_r == OP_DIV) ? {lo[WIDTH-2:0], ge} : {sum[0], lo[WIDTH-1:1]};
    hi_next = (op_r == OP_DIV) ? (ge ? diff : rem_sh[WIDTH-1:0]) : sum[WIDTH:1];
  end
  // operand latch on load, one iteration per step
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r <= OP_MUL;
      opnd <= '0;
      lo   <= '0;
      hi   <= '0;
    end else if (load) begin
      op_r <= op;
      opnd <= (op == OP_DIV) ? b : a;
      lo   <= (op == OP_DIV) ? a : b;
      hi   <= '0;
    end else if (step) begin
      lo <= lo_next;
      hi <= hi_next;
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative 8-bit multiply/divide unit with IDLE/RUN/DONE sequencing
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic        clk,
  input logic        rst,
  muldiv_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic             load;
  logic [WIDTH-1:0] lo_next;
  logic [WIDTH-1:0] hi_next;
  assign load = bus.start && state != RUN;
  muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk(clk), .rst(rst), .load(load), .step(state == RUN), .op(bus.op),
    .a(bus.a), .b(bus.b), .lo_next(lo_next), .hi_next(hi_next)
  );
  // sequencing FSM with registered handshake outputs; results captured only on DONE entry
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.result    <= '0;
      bus.result_hi <= '0;
      bus.div_zero  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.result    <= lo_next;
            bus.result_hi <= hi_next;
          end
        end
        default: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            cnt          <= CW'(WIDTH);
            bus.div_zero <= 1'b0;
            if (bus.op == OP_DIV && bus.b == '0) begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.busy      <= 1'b0;
              bus.result    <= '1;
              bus.result_hi <= bus.a;
              bus.div_zero  <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for the iterative mul/div unit
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int fails = 0;
  int c;
  int busy_cnt;
  int done_cnt;
  muldiv_seq_if bus ();
  muldiv_seq dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // apply start for one edge, then count cycles (c) and busy cycles until done
  task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y, input logic hold);
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    tick();
    bus.start = hold;
    bus.a = 8'h3C;
    bus.b = 8'h05;
    c = 1;
    busy_cnt = 0;
    while (!bus.done && c < 40) begin
      busy_cnt += int'(bus.busy);
      tick();
      c++;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_result_hi", 32'(bus.result_hi), 0);
    chk("rst_div_zero", 32'(bus.div_zero), 0);

    run_op(1'b0, 8'h0D, 8'h0B, 1'b0);
    chk("mul13x11_latency", c, 9);
    chk("mul13x11_busy", busy_cnt, 8);
    chk("mul13x11_lo", 32'(bus.result), 32'h8F);
    chk("mul13x11_hi", 32'(bus.result_hi), 32'h00);
    chk("mul13x11_dz", 32'(bus.div_zero), 0);
    tick();
    chk("mul13x11_pulse", 32'(bus.done), 0);
    chk("mul13x11_hold", 32'(bus.result), 32'h8F);

    run_op(1'b0, 8'hFF, 8'hFF, 1'b0);
    chk("mul255_latency", c, 9);
    chk("mul255_busy", busy_cnt, 8);
    chk("mul255_lo", 32'(bus.result), 32'h01);
    chk("mul255_hi", 32'(bus.result_hi), 32'hFE);
    tick();

    run_op(1'b1, 8'hC8, 8'h07, 1'b0);
    chk("div200_7_latency", c, 9);
    chk("div200_7_q", 32'(bus.result), 32'h1C);
    chk("div200_7_r", 32'(bus.result_hi), 32'h04);
    chk("div200_7_dz", 32'(bus.div_zero), 0);
    tick();
    chk("div200_7_pulse", 32'(bus.done), 0);

    run_op(1'b1, 8'h55, 8'h00, 1'b0);
    chk("divz_latency", c, 1);
    chk("divz_busy", busy_cnt, 0);
    chk("divz_q", 32'(bus.result), 32'hFF);
    chk("divz_r", 32'(bus.result_hi), 32'h55);
    chk("divz_flag", 32'(bus.div_zero), 1);
    tick();
    chk("divz_pulse", 32'(bus.done), 0);
    chk("divz_flag_hold", 32'(bus.div_zero), 1);

    run_op(1'b0, 8'h02, 8'h03, 1'b0);
    chk("after_divz_lo", 32'(bus.result), 32'h06);
    chk("after_divz_dz", 32'(bus.div_zero), 0);
    tick();

    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.a = 8'h0D;
    bus.b = 8'h0B;
    tick();
    bus.start = 1'b1;
    bus.op = 1'b1;
    bus.a = 8'h90;
    bus.b = 8'h03;
    tick();
    bus.start = 1'b0;
    chk("run_start_busy", 32'(bus.busy), 1);
    chk("run_result_stable", 32'(bus.result), 32'h06);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    chk("abort_result", 32'(bus.result), 0);
    chk("abort_result_hi", 32'(bus.result_hi), 0);
    chk("abort_div_zero", 32'(bus.div_zero), 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      done_cnt += int'(bus.done);
      tick();
    end
    chk("abort_no_done", done_cnt, 0);

    bus.start = 1'b1;
    bus.op = 1'b0;
    bus.a = 8'h06;
    bus.b = 8'h07;
    tick();
    bus.op = 1'b1;
    bus.a = 8'd100;
    bus.b = 8'd9;
    c = 1;
    while (!bus.done && c < 40) begin
      tick();
      c++;
    end
    chk("b2b_first_latency", c, 9);
    chk("b2b_first_lo", 32'(bus.result), 32'h2A);
    chk("b2b_first_hi", 32'(bus.result_hi), 32'h00);
    tick();
    bus.start = 1'b0;
    c = 1;
    while (!bus.done && c < 40) begin
      tick();
      c++;
    end
    chk("b2b_spacing", c, 9);
    chk("b2b_second_q", 32'(bus.result), 32'h0B);
    chk("b2b_second_r", 32'(bus.result_hi), 32'h01);
    tick();
    chk("b2b_idle", 32'(bus.done), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
